rob_ctrl: RTL
=============

// Module: rob_ctrl
// PURPOSE
//  Parametrised reorder-buffer controller; successor to the single-issue ROB tracker.
//  Allocates ROB indices in program order at dispatch and marks entries complete on writeback.
//  Retires up to COMMIT_WIDTH completed entries per cycle, in order.
//  On a memory-order violation, squashes the violating entry and all younger entries.
//  Sits between rename/dispatch, the execution writeback buses and the commit stage.
// PARAMETERS
//  ROB_NUM       32  entry count; power of 2, >=4
//  ROB_SEL       5   $clog2(ROB_NUM); index width
//  NUM_WB        2   writeback (completion) ports
//  COMMIT_WIDTH  2   max retirements per cycle; 1..4
// PORTS
//  clk                input   1                      clock, rising edge
//  reset_n            input   1                      asynchronous active-low reset
//  dispatch_valid     input   1                      request to allocate one entry
//  dispatch_ready     output  1                      entry can be allocated this cycle
//  dispatch_rob_idx   output  ROB_SEL                index that a dispatch this cycle receives (tail)
//  wb_valid           input   NUM_WB                 per-port completion strobe
//  wb_rob_idx         input   NUM_WB*ROB_SEL         completing index; port p is at [p*ROB_SEL +: ROB_SEL]
//  commit_enable      input   1                      commit stage accepts retirements this cycle
//  commit_valid       output  COMMIT_WIDTH           slot k retires this cycle; always a contiguous prefix
//  commit_rob_idx     output  COMMIT_WIDTH*ROB_SEL   slot k index = head+k (mod ROB_NUM)
//  violation_valid    input   1                      memory-order violation flush request
//  violation_rob_idx  input   ROB_SEL                oldest entry to squash
//  rob_full           output  1                      count == ROB_NUM
//  rob_empty          output  1                      count == 0
//  rob_count          output  ROB_SEL+1              number of occupied entries
// BEHAVIOUR
//  State
//   - head_ptr and tail_ptr are ROB_SEL+1 bits; the MSB is the wrap bit.
//   - Per-entry bits valid[] and done[].
//   - count = tail_ptr - head_ptr, computed modulo 2^(ROB_SEL+1).
//  Reset (reset_n low, asynchronous)
//   - head_ptr = tail_ptr = 0; all valid and done bits = 0.
//   - Outputs: rob_empty=1, rob_full=0, rob_count=0, commit_valid=0, dispatch_ready=1, dispatch_rob_idx=0.
//   - Reset asserted mid-operation discards all entries immediately.
//  Combinational outputs
//   - All outputs are combinational from registered state and current inputs.
//   - dispatch_ready = !rob_full && !violation_valid.
//  Dispatch
//   - A dispatch occurs when dispatch_valid && dispatch_ready.
//   - Next cycle: valid[tail]=1, done[tail]=0, tail_ptr += 1.
//   - Zero-cycle latency: dispatch_rob_idx is tail_ptr[ROB_SEL-1:0] in the dispatch cycle itself.
//  Writeback
//   - For each port with wb_valid set: if valid[idx], set done[idx]=1 at the next edge.
//   - A writeback to an invalid entry is ignored.
//   - Two ports may target the same index; the result is the same.
//  Commit
//   - commit_valid[k] = commit_enable && (k < count) && done[head+k] && commit_valid[k-1].
//   - Slot 0 has no commit_valid[k-1] term.
//   - Slot k is additionally blocked if violation_valid && (head+k) is at or younger than violation_rob_idx.
//   - Each committed entry clears valid/done at the next edge; head_ptr += popcount(commit_valid).
//  Violation
//   - Accepted only if valid[violation_rob_idx] is set; otherwise the request is ignored.
//   - On acceptance: every entry from violation_rob_idx through tail-1 is cleared.
//   - tail_ptr is set to the pointer of violation_rob_idx, wrap bit reconstructed relative to head.
//   - The cycle's dispatch is blocked by dispatch_ready being low.
//   - Writebacks to squashed entries in the same cycle are dropped.
//   - Commits of older entries in the same cycle proceed.
//  Simultaneous events
//   - Dispatch and commit in the same cycle is legal.
//   - When full with both present: dispatch_ready=0 (full wins); commit still drains.
//  Wrap-around
//   - Indices wrap modulo ROB_NUM.
//   - full when the index bits of head and tail are equal and their wrap bits differ.
// TESTING
//  1. Reset, then dispatch 32 consecutive ->
//     - indices 0..31 issued
//     - rob_full=1 after the 32nd; dispatch_ready=0; 33rd dispatch not accepted.
//  2. Entries 0..3 valid; wb 2 then wb 0,1 ->
//     - no commit until idx0 done
//     - then commit 0,1 in one cycle, then 2 in the next (COMMIT_WIDTH=2); count 4->2->1.
//  3. Entries 0..9 valid; violation_rob_idx=5 ->
//     - next cycle tail=5, count=5, entries 5..9 invalid
//     - a later wb to idx 7 is ignored; the next dispatch gets idx 5.
//  4. head=30, dispatch 6 ->
//     - indices 30,31,0,1,2,3 issued; count=6
//     - commit all of them; rob_empty=1 with head_ptr=36 (mod 64).
//  5. Full ROB, commit_enable with 2 done plus dispatch_valid in the same cycle ->
//     - 2 entries commit, no dispatch accepted; next cycle rob_full=0, count=30.
//  6. reset_n pulsed low mid-traffic (no clock edge) ->
//     - outputs immediately at their reset values; rob_empty=1, commit_valid=0.

Source files
------------

// File: rtl/rob_ctrl_if.sv
// rob_ctrl_if: groups the dispatch, writeback, commit, violation and status signals
// of the reorder-buffer controller.
//   master : rename/dispatch, writeback and commit side (drives requests, observes status)
//   slave  : the ROB controller itself
//   dispatch_valid/ready/rob_idx  allocation handshake and allocated index
//   wb_valid/wb_rob_idx           per-port completion strobes, port p at [p*ROB_SEL +: ROB_SEL]
//   commit_enable/valid/rob_idx   retirement slots, contiguous prefix, slot k = head+k
//   violation_valid/rob_idx       squash request, oldest entry to discard
//   rob_full/rob_empty/rob_count  occupancy status
interface rob_ctrl_if #(
  parameter int unsigned ROB_SEL      = 5,
  parameter int unsigned NUM_WB       = 2,
  parameter int unsigned COMMIT_WIDTH = 2
);
  logic                            dispatch_valid;
  logic                            dispatch_ready;
  logic [ROB_SEL-1:0]              dispatch_rob_idx;
  logic [NUM_WB-1:0]               wb_valid;
  logic [NUM_WB*ROB_SEL-1:0]       wb_rob_idx;
  logic                            commit_enable;
  logic [COMMIT_WIDTH-1:0]         commit_valid;
  logic [COMMIT_WIDTH*ROB_SEL-1:0] commit_rob_idx;
  logic                            violation_valid;
  logic [ROB_SEL-1:0]              violation_rob_idx;
  logic                            rob_full;
  logic                            rob_empty;
  logic [ROB_SEL:0]                rob_count;

  modport master (
    output dispatch_valid, wb_valid, wb_rob_idx, commit_enable, violation_valid,
           violation_rob_idx,
    input  dispatch_ready, dispatch_rob_idx, commit_valid, commit_rob_idx, rob_full,
           rob_empty, rob_count
  );

  modport slave (
    input  dispatch_valid, wb_valid, wb_rob_idx, commit_enable, violation_valid,
           violation_rob_idx,
    output dispatch_ready, dispatch_rob_idx, commit_valid, commit_rob_idx, rob_full,
           rob_empty, rob_count
  );
endinterface

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller. Allocates indices in program order at dispatch,
// marks entries done on writeback, retires up to COMMIT_WIDTH done entries per cycle in
// order, and squashes an entry plus everything younger on a memory-order violation.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; discards all entries
//   bus      rob_ctrl_if.slave (dispatch, writeback, commit, violation, status)
// All bus outputs are combinational from registered state and current inputs.
module rob_ctrl #(
  parameter int unsigned ROB_NUM      = 32,
  parameter int unsigned ROB_SEL      = 5,
  parameter int unsigned NUM_WB       = 2,
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input logic         clk,
  input logic         reset_n,
  rob_ctrl_if.slave   bus
);

  localparam int unsigned PtrW = ROB_SEL + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0]    head_ptr_q, head_ptr_d;
  logic [PtrW-1:0]    tail_ptr_q, tail_ptr_d;
  logic [ROB_NUM-1:0] valid_q, valid_d;
  logic [ROB_NUM-1:0] done_q, done_d;

  logic [PtrW-1:0]    count;
  logic [ROB_SEL-1:0] head_idx;
  logic [ROB_SEL-1:0] tail_idx;
  logic [ROB_SEL-1:0] vio_age;
  logic               vio_accept;
  logic               dispatch_fire;
  logic [PtrW-1:0]    n_commit;
  logic               prev_ok;
  logic               slot_ok;
  logic [ROB_SEL-1:0] slot_idx;
  logic [ROB_SEL-1:0] wb_idx;

  // Age = distance from the head; a larger age means younger in program order.
  function automatic logic [ROB_SEL-1:0] age_of(input logic [ROB_SEL-1:0] idx,
                                                input logic [ROB_SEL-1:0] head);
    return idx - head;
  endfunction

  assign count      = tail_ptr_q - head_ptr_q;
  assign head_idx   = head_ptr_q[ROB_SEL-1:0];
  assign tail_idx   = tail_ptr_q[ROB_SEL-1:0];
  assign vio_age    = age_of(bus.violation_rob_idx, head_idx);
  assign vio_accept = bus.violation_valid && valid_q[bus.violation_rob_idx];

  assign bus.rob_count        = count;
  assign bus.rob_full         = (count == PtrW'(ROB_NUM));
  assign bus.rob_empty        = (count == '0);
  assign bus.dispatch_ready   = !bus.rob_full && !bus.violation_valid;
  assign bus.dispatch_rob_idx = tail_idx;
  assign dispatch_fire        = bus.dispatch_valid && bus.dispatch_ready;

  // Commit slots form a contiguous prefix. A pending violation blocks every slot at or
  // younger than the violating entry; an invalid violation index has an age >= count,
  // so it never blocks an occupied slot.
  always_comb begin
    bus.commit_valid   = '0;
    bus.commit_rob_idx = '0;
    n_commit           = '0;
    prev_ok            = 1'b1;
    slot_ok            = 1'b0;
    slot_idx           = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx = head_idx + ROB_SEL'(k);
      bus.commit_rob_idx[k*ROB_SEL +: ROB_SEL] = slot_idx;
      slot_ok = prev_ok && bus.commit_enable && (PtrW'(k) < count) && done_q[slot_idx] &&
                !(bus.violation_valid && (ROB_SEL'(k) >= vio_age));
      bus.commit_valid[k] = slot_ok;
      prev_ok = slot_ok;
      if (slot_ok) n_commit = n_commit + PtrW'(1);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    head_ptr_d = head_ptr_q + n_commit;
    tail_ptr_d = tail_ptr_q;
    wb_idx     = '0;

    // Writebacks land only on live entries that are not being squashed this cycle.
    for (int p = 0; p < NUM_WB; p++) begin
      wb_idx = bus.wb_rob_idx[p*ROB_SEL +: ROB_SEL];
      if (bus.wb_valid[p] && valid_q[wb_idx] &&
          !(vio_accept && (age_of(wb_idx, head_idx) >= vio_age))) begin
        done_d[wb_idx] = 1'b1;
      end
    end

    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (bus.commit_valid[k]) begin
        valid_d[head_idx + ROB_SEL'(k)] = 1'b0;
        done_d[head_idx + ROB_SEL'(k)]  = 1'b0;
      end
    end

    if (vio_accept) begin
      for (int i = 0; i < ROB_NUM; i++) begin
        if (age_of(ROB_SEL'(i), head_idx) >= vio_age) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      // Rebuild the tail's wrap bit from the head and the violator's age.
      tail_ptr_d = head_ptr_q + {1'b0, vio_age};
    end else if (dispatch_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_ptr_d        = tail_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      valid_q    <= '0;
      done_q     <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

endmodule
